// File: rtl/multdiv.sv
// Iterative 32-bit signed multiply/divide unit: radix-2 Booth multiply and
// restoring divide, one step per cycle, 32 cycles per operation.
module multdiv (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [31:0] mag32(input logic [31:0] v);
    mag32 = v[31] ? (~v + 32'd1) : v;
  endfunction

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic        isDiv_r;
  logic        negQ_r;
  logic        divZero_r;
  logic        divOvf_r;
  logic [32:0] hi_r;
  logic [31:0] lo_r;
  logic        q1_r;
  logic [32:0] opX_r;

  logic        start_s;
  logic        startDiv_s;
  logic [32:0] sum_s;
  logic [32:0] remSh_s;
  logic [32:0] diff_s;
  logic        qBit_s;
  logic [32:0] hiN_s;
  logic [31:0] loN_s;
  logic        q1N_s;
  logic [31:0] quo_s;
  logic [31:0] finRes_s;
  logic        finExc_s;

  // Multiply wins when both start pulses arrive together.
  assign start_s    = ctrl_MULT | ctrl_DIV;
  assign startDiv_s = ctrl_DIV & ~ctrl_MULT;

  // One Booth step or one restoring-divide step on the working registers.
  always_comb begin
    sum_s   = hi_r;
    remSh_s = {hi_r[31:0], lo_r[31]};
    diff_s  = remSh_s - opX_r;
    qBit_s  = 1'b0;
    hiN_s   = hi_r;
    loN_s   = lo_r;
    q1N_s   = q1_r;
    if (isDiv_r) begin
      if (diff_s[32]) begin
        hiN_s  = remSh_s;
        qBit_s = 1'b0;
      end else begin
        hiN_s  = diff_s;
        qBit_s = 1'b1;
      end
      loN_s = {lo_r[30:0], qBit_s};
      q1N_s = 1'b0;
    end else begin
      case ({lo_r[0], q1_r})
        2'b01:   sum_s = hi_r + opX_r;
        2'b10:   sum_s = hi_r - opX_r;
        default: sum_s = hi_r;
      endcase
      hiN_s = {sum_s[32], sum_s[32:1]};
      loN_s = {sum_s[0], lo_r[31:1]};
      q1N_s = lo_r[0];
    end
  end

  // Final result and exception as seen after the last step.
  always_comb begin
    quo_s = negQ_r ? (~loN_s + 32'd1) : loN_s;
    if (isDiv_r) begin
      finRes_s = divZero_r ? 32'd0 : quo_s;
      finExc_s = divZero_r | divOvf_r;
    end else begin
      finRes_s = loN_s;
      finExc_s = (hiN_s[31:0] != {32{loN_s[31]}});
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      cnt_r          <= 5'd0;
      isDiv_r        <= 1'b0;
      negQ_r         <= 1'b0;
      divZero_r      <= 1'b0;
      divOvf_r       <= 1'b0;
      hi_r           <= 33'd0;
      lo_r           <= 32'd0;
      q1_r           <= 1'b0;
      opX_r          <= 33'd0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (start_s) begin
      // A start on the final step still completes the old op.
      if (state_r == RUN && cnt_r == 5'd31) begin
        data_result    <= finRes_s;
        data_exception <= finExc_s;
        data_resultRDY <= 1'b1;
      end else begin
        data_resultRDY <= 1'b0;
      end
      state_r   <= RUN;
      busy      <= 1'b1;
      cnt_r     <= 5'd0;
      isDiv_r   <= startDiv_s;
      negQ_r    <= data_operandA[31] ^ data_operandB[31];
      divZero_r <= (data_operandB == 32'd0);
      divOvf_r  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      hi_r      <= 33'd0;
      q1_r      <= 1'b0;
      if (startDiv_s) begin
        lo_r  <= mag32(data_operandA);
        opX_r <= {1'b0, mag32(data_operandB)};
      end else begin
        lo_r  <= data_operandB;
        opX_r <= {data_operandA[31], data_operandA};
      end
    end else begin
      case (state_r)
        RUN: begin
          hi_r  <= hiN_s;
          lo_r  <= loN_s;
          q1_r  <= q1N_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            data_result    <= finRes_s;
            data_exception <= finExc_s;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state_r        <= DONE;
          end else begin
            data_resultRDY <= 1'b0;
            busy           <= 1'b1;
            state_r        <= RUN;
          end
        end
        DONE: begin
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
          state_r        <= IDLE;
        end
        default: begin
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Directed-vector bench for multdiv with hand-computed expected results.
module tb_multdiv;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int nVec = 0;
  int nMis = 0;

  multdiv dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a start pulse sampled at the next rising edge; return #1 after it.
  task automatic startOp(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Watch up to maxCyc edges, capturing the first RDY pulse.
  task automatic waitRdy(input int maxCyc, output int rdyAt, output int nRdy,
                         output logic [31:0] res, output logic exc,
                         output logic busyMid, output logic busyAtRdy);
    rdyAt = 0; nRdy = 0; res = 32'd0; exc = 1'b0; busyMid = 1'b0; busyAtRdy = 1'b1;
    for (int i = 1; i <= maxCyc; i++) begin
      @(posedge clock);
      #1;
      if (i == 31) busyMid = busy;
      if (data_resultRDY) begin
        nRdy++;
        if (rdyAt == 0) begin
          rdyAt = i;
          res = data_result;
          exc = data_exception;
          busyAtRdy = busy;
        end
      end
    end
  endtask

  task automatic doOp(input string tag, input logic m, input logic d,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expRes, input logic expExc);
    int rdyAt, nRdy;
    logic [31:0] res;
    logic exc, busyMid, busyAtRdy;
    startOp(m, d, a, b);
    chk({tag, ".busyE0"}, 32'(busy), 32'd1);
    waitRdy(40, rdyAt, nRdy, res, exc, busyMid, busyAtRdy);
    chk({tag, ".rdyAt"}, 32'(rdyAt), 32'd32);
    chk({tag, ".nRdy"}, 32'(nRdy), 32'd1);
    chk({tag, ".result"}, res, expRes);
    chk({tag, ".exc"}, 32'(exc), 32'(expExc));
    chk({tag, ".busyE31"}, 32'(busyMid), 32'd1);
    chk({tag, ".busyE32"}, 32'(busyAtRdy), 32'd0);
  endtask

  initial begin
    int rdyAt, nRdy;
    logic [31:0] res;
    logic exc, busyMid, busyAtRdy;

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst.result", data_result, 32'd0);
    chk("rst.exc", 32'(data_exception), 32'd0);
    chk("rst.rdy", 32'(data_resultRDY), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);

    doOp("mul7xm3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    doOp("mulOvf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    doOp("mulM1xM1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    doOp("divM7by2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    doOp("div100by7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0);
    doOp("divM100by7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
    doOp("div7byM100", 1'b0, 1'b1, 32'd7, 32'hFFFF_FF9C, 32'd0, 1'b0);
    doOp("divBy0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
    doOp("divOvf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    doOp("bothStart", 1'b1, 1'b1, 32'd6, 32'd5, 32'd30, 1'b0);

    // Restart: a multiply at cycle 10 aborts a running divide.
    startOp(1'b0, 1'b1, 32'd100, 32'd7);
    waitRdy(9, rdyAt, nRdy, res, exc, busyMid, busyAtRdy);
    chk("restart.noRdyOld", 32'(nRdy), 32'd0);
    startOp(1'b1, 1'b0, 32'd3, 32'd4);
    waitRdy(40, rdyAt, nRdy, res, exc, busyMid, busyAtRdy);
    chk("restart.rdyAt", 32'(rdyAt), 32'd32);
    chk("restart.nRdy", 32'(nRdy), 32'd1);
    chk("restart.result", res, 32'd12);

    // Back-to-back: a new start sampled on the completing edge.
    startOp(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (31) @(posedge clock);
    startOp(1'b0, 1'b1, 32'd100, 32'd7);
    chk("b2b.rdyOld", 32'(data_resultRDY), 32'd1);
    chk("b2b.resultOld", data_result, 32'd12);
    chk("b2b.busy", 32'(busy), 32'd1);
    waitRdy(40, rdyAt, nRdy, res, exc, busyMid, busyAtRdy);
    chk("b2b.rdyAtNew", 32'(rdyAt), 32'd32);
    chk("b2b.nRdyNew", 32'(nRdy), 32'd1);
    chk("b2b.resultNew", res, 32'd14);

    // Asynchronous reset in the middle of a multiply.
    startOp(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    repeat (15) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midRst.result", data_result, 32'd0);
    chk("midRst.exc", 32'(data_exception), 32'd0);
    chk("midRst.rdy", 32'(data_resultRDY), 32'd0);
    chk("midRst.busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    waitRdy(40, rdyAt, nRdy, res, exc, busyMid, busyAtRdy);
    chk("midRst.noRdy", 32'(nRdy), 32'd0);
    doOp("afterRst", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
